// File: rtl/cmd_cntrl_q.sv
// Multi-stop command controller: GO/QUEUE/STOP commands fill a station FIFO,
// matching barcode IDs pop it, and a piezo driver sounds while blocked in transit.
module cmd_cntrl_q #(
  parameter int ID_W      = 6,
  parameter int DEPTH     = 4,
  parameter int BUZZ_HALF = 12500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W+1:0]          cmd,
  input  logic                     cmd_rdy,
  input  logic [ID_W+1:0]          ID,
  input  logic                     ID_vld,
  input  logic                     OK2Move,
  output logic                     clr_cmd_rdy,
  output logic                     clr_ID_vld,
  output logic                     in_transit,
  output logic                     go,
  output logic                     buzz,
  output logic                     buzz_n,
  output logic [ID_W-1:0]          dest,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     arrived,
  output logic                     cmd_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BUZZ_HALF + 1);

  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_WRAP = BW'(BUZZ_HALF - 1);

  localparam logic [1:0] OP_GO    = 2'b01;
  localparam logic [1:0] OP_QUEUE = 2'b10;

  typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d, push_idx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push;
  logic              clr_cmd_q, clr_id_q;
  logic              arrived_q, arrived_d, drop_q, drop_d;
  logic [BW-1:0]     bcnt_q;
  logic              tgl_q;

  logic              cmd_take, id_take, id_match, full, moving, buzz_act;
  logic [1:0]        op;
  logic [ID_W-1:0]   st;

  // The ack register blanks the request for one cycle so a held request
  // is never consumed twice by the same acknowledge.
  assign cmd_take = cmd_rdy & ~clr_cmd_q;
  assign id_take  = ID_vld  & ~clr_id_q;
  assign op       = cmd[ID_W+1:ID_W];
  assign st       = cmd[ID_W-1:0];
  assign moving   = (state_q == MOVING);
  assign full     = (cnt_q == C_FULL);
  assign dest     = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign id_match = id_take & moving & (ID[ID_W+1:ID_W] == 2'b00) &
                    (ID[ID_W-1:0] == dest);

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_idx  = wr_q;
    arrived_d = 1'b0;
    drop_d    = 1'b0;
    if (cmd_take) begin
      case (op)
        OP_GO: begin
          rd_d     = '0;
          wr_d     = P_ONE;
          cnt_d    = C_ONE;
          push     = 1'b1;
          push_idx = '0;
          state_d  = MOVING;
        end
        OP_QUEUE: begin
          if (id_match) begin
            // Pop and push together: when full, the write lands in the slot
            // being freed (wr == rd), so occupancy is unchanged.
            rd_d = rd_q + P_ONE;
            wr_d = wr_q + P_ONE;
            push = 1'b1;
          end else if (full) begin
            drop_d = 1'b1;
          end else begin
            wr_d    = wr_q + P_ONE;
            cnt_d   = cnt_q + C_ONE;
            push    = 1'b1;
            state_d = MOVING;
          end
        end
        default: begin
          rd_d    = '0;
          wr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end else if (id_match) begin
      rd_d  = rd_q + P_ONE;
      cnt_d = cnt_q - C_ONE;
      if (cnt_q == C_ONE) begin
        state_d   = IDLE;
        arrived_d = 1'b1;
      end
    end
  end

  assign buzz_act = moving & ~OK2Move;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      clr_cmd_q <= 1'b0;
      clr_id_q  <= 1'b0;
      arrived_q <= 1'b0;
      drop_q    <= 1'b0;
      bcnt_q    <= '0;
      tgl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      clr_cmd_q <= cmd_take;
      clr_id_q  <= id_take;
      arrived_q <= arrived_d;
      drop_q    <= drop_d;
      if (push) mem_q[push_idx] <= st;
      if (!buzz_act) begin
        bcnt_q <= '0;
        tgl_q  <= 1'b0;
      end else if (bcnt_q == B_WRAP) begin
        bcnt_q <= '0;
        tgl_q  <= ~tgl_q;
      end else begin
        bcnt_q <= bcnt_q + B_ONE;
      end
    end
  end

  assign in_transit  = moving;
  assign go          = moving & OK2Move;
  assign buzz        = buzz_act & ~tgl_q;
  assign buzz_n      = buzz_act & tgl_q;
  assign q_cnt       = cnt_q;
  assign clr_cmd_rdy = clr_cmd_q;
  assign clr_ID_vld  = clr_id_q;
  assign arrived     = arrived_q;
  assign cmd_drop    = drop_q;

endmodule
